// File: rtl/booth_multiplier_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states and Booth op decode.
package booth_multiplier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // Radix-2 Booth recoding of the current multiplier bit pair {P[1], P[0]}.
   function automatic booth_op_t booth_decode(input logic [1:0] pair);
      booth_op_t op;
      case (pair)
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_multiplier_addsub.sv
// Ripple-carry add/sub engine: o_sum_c = i_a + (i_sub ? ~i_b : i_b) + i_sub, carry-out dropped.
module booth_addsub #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum_c
);

   logic [W-1:0] w_b;
   logic [W-1:0] w_carry;

   assign w_b        = i_b ^ {W{i_sub}};
   assign w_carry[0] = i_sub;

   // One full-adder slice per bit; the final carry-out has no consumer.
   for (genvar g = 0; g < W; g++) begin : g_slice
      assign o_sum_c[g] = i_a[g] ^ w_b[g] ^ w_carry[g];
      if (g < W - 1) begin : g_carry
         assign w_carry[g+1] = (i_a[g] & w_b[g]) | (w_carry[g] & (i_a[g] ^ w_b[g]));
      end
   end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative radix-2 Booth multiplier: signed WIDTH x WIDTH, one add/sub per cycle.
module booth_multiplier
   import booth_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int unsigned HW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH + 2;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [PW-1:0]      r_p, w_p_nxt;
   logic [HW-1:0]      r_m, w_m_nxt;
   logic [WIDTH-1:0]   r_result, w_result_nxt;
   logic               r_exc, w_exc_nxt;
   logic               r_rdy, w_rdy_nxt;
   logic               r_busy, w_busy_nxt;

   booth_op_t          w_op;
   logic [HW-1:0]      w_hi;
   logic [HW-1:0]      w_sum;
   logic [HW-1:0]      w_hi_new;
   logic [PW-1:0]      w_p_iter;
   logic [2*WIDTH-1:0] w_product;

   assign w_op = booth_decode(r_p[1:0]);
   assign w_hi = r_p[PW-1:WIDTH+1];

   booth_addsub #(.W(HW)) u_addsub (
      .i_a     (w_hi),
      .i_b     (r_m),
      .i_sub   (w_op == OP_SUB),
      .o_sum_c (w_sum)
   );

   // One Booth step: conditional add/sub into the hi half, then arithmetic shift right.
   assign w_hi_new  = (w_op == OP_NOP) ? w_hi : w_sum;
   assign w_p_iter  = {w_hi_new[WIDTH], w_hi_new, r_p[WIDTH:1]};
   assign w_product = {w_hi_new, r_p[WIDTH:2]};

   // Next-state, datapath and output decisions; a start pulse wins in every state.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_p_nxt      = r_p;
      w_m_nxt      = r_m;
      w_result_nxt = r_result;
      w_exc_nxt    = r_exc;
      w_rdy_nxt    = 1'b0;
      w_busy_nxt   = 1'b0;

      if (ctrl_MULT) begin
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = '0;
         w_p_nxt     = {HW'(0), data_operandB, 1'b0};
         w_m_nxt     = {data_operandA[WIDTH-1], data_operandA};
         w_busy_nxt  = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               w_p_nxt   = w_p_iter;
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  w_state_nxt  = ST_DONE;
                  w_result_nxt = w_product[WIDTH-1:0];
                  w_exc_nxt    = (w_product[2*WIDTH-1:WIDTH] != {WIDTH{w_product[WIDTH-1]}});
                  w_rdy_nxt    = 1'b1;
               end else begin
                  w_busy_nxt = 1'b1;
               end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_p      <= '0;
         r_m      <= '0;
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_p      <= w_p_nxt;
         r_m      <= w_m_nxt;
         r_result <= w_result_nxt;
         r_exc    <= w_exc_nxt;
         r_rdy    <= w_rdy_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = r_rdy;
   assign busy           = r_busy;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier with a product scoreboard built from a 64-bit reference multiply.
module tb_booth_multiplier;

   localparam int unsigned WIDTH = 32;

   logic             clock = 1'b0;
   logic             reset;
   logic             ctrl_MULT;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   int checks   = 0;
   int failures = 0;
   int rdy_cnt  = 0;
   int c0;
   logic [32:0] sb_q[$];

   booth_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (data_resultRDY === 1'b1) rdy_cnt++;

   // Reference: {exception, low word} of the full signed 64-bit product.
   function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
      longint     p;
      logic [63:0] u;
      p = longint'($signed(a)) * longint'($signed(b));
      u = p;
      return {(u[63:32] != {32{u[31]}}), u[31:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit push);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      if (push) sb_q.push_back(model(a, b));
      tick();
      ctrl_MULT     = 1'b0;
   endtask

   // Called in cycle 1 of an op; RDY must appear exactly WIDTH cycles later, for one cycle.
   task automatic wait_rdy(input string tag);
      int n;
      logic [32:0] exp;
      n = 0;
      while (data_resultRDY !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(WIDTH));
      check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
         exp = sb_q.pop_front();
         check({tag, "_result"}, 64'(data_result), 64'(exp[31:0]));
         check({tag, "_exc"}, 64'(data_exception), 64'(exp[32]));
      end
      tick();
      check({tag, "_rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
      check({tag, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      ctrl_MULT = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) tick();
      check("rst_result", 64'(data_result), 64'd0);
      check("rst_exc", 64'(data_exception), 64'd0);
      check("rst_rdy", 64'(data_resultRDY), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      repeat (5) tick();
      check("no_spurious_rdy", 64'(rdy_cnt), 64'd0);

      do_start(32'd3, 32'd5, 1'b1);
      check("t1_busy", 64'(busy), 64'd1);
      wait_rdy("t1");

      do_start(32'hFFFF_FFF9, 32'd6, 1'b1);
      wait_rdy("t2");

      do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_rdy("t3");
      repeat (3) tick();
      check("t3_hold_result", 64'(data_result), 64'h8000_0000);
      check("t3_hold_exc", 64'(data_exception), 64'd1);

      do_start(32'h0001_0000, 32'h0001_0000, 1'b1);
      check("t4_hold_during_run", 64'(data_result), 64'h8000_0000);
      wait_rdy("t4a");
      do_start(32'd0, 32'h7FFF_FFFF, 1'b1);
      wait_rdy("t4b");

      do_start(32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_rdy("minmin");
      do_start(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      wait_rdy("maxmin");
      for (int i = 0; i < 3; i++) begin
         do_start($urandom, $urandom, 1'b1);
         wait_rdy("rand");
      end

      c0 = rdy_cnt;
      do_start(32'd2, 32'd3, 1'b0);
      repeat (9) tick();
      do_start(32'd4, 32'd4, 1'b1);
      wait_rdy("t5");
      repeat (5) tick();
      check("t5_single_rdy", 64'(rdy_cnt - c0), 64'd1);

      do_start(32'd9, 32'd9, 1'b0);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("t6_result", 64'(data_result), 64'd0);
      check("t6_exc", 64'(data_exception), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_rdy", 64'(data_resultRDY), 64'd0);
      reset = 1'b0;
      c0 = rdy_cnt;
      repeat (40) tick();
      check("t6_no_rdy", 64'(rdy_cnt - c0), 64'd0);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
